// File: rtl/aes_out_buffer_if.sv
// Block ingress from the cipher pipeline plus the 32-bit word egress stream of aes_out_buffer.
// The buffer drives the word stream (master); the pipeline/consumer side uses slave.
interface aes_out_buffer_if;
  logic [127:0] blk_in;
  logic         blk_in_valid;
  logic [31:0]  word_out;
  logic         word_valid;
  logic         word_ready;
  logic         word_last;

  modport master (
    input  blk_in, blk_in_valid, word_ready,
    output word_out, word_valid, word_last
  );

  modport slave (
    output blk_in, blk_in_valid, word_ready,
    input  word_out, word_valid, word_last
  );
endinterface

// File: rtl/aes_out_buffer.sv
// Ciphertext block FIFO + MSW-first 128->32 serializer; optional drop counter via AES_OUTBUF_DROP_CNT_EN.
// Latency: block captured at edge N is presented as word 0 during cycle N+1.
// Backpressure: word_ready stalls the serializer; blocks arriving while full are dropped (sticky overflow).
module aes_out_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  aes_out_buffer_if.master bus,
  input  logic             flush,
  output logic [CW-1:0]    free_cnt,
  output logic             empty,
  output logic             full,
  output logic             overflow
`ifdef AES_OUTBUF_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t        state;
  logic [127:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [1:0]    widx;
  logic [127:0]  head;
  logic          xfer;
  logic          pop;
  logic          push;
  logic          drop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign free_cnt = CW'(DEPTH) - count;

  assign bus.word_valid = (state == SEND);
  assign bus.word_last  = bus.word_valid && (widx == 2'd3);

  // Head slice depends only on registered state, so it holds while stalled.
  assign head = mem[rd_ptr];
  always_comb begin
    bus.word_out = head[127:96];
    case (widx)
      2'd1:    bus.word_out = head[95:64];
      2'd2:    bus.word_out = head[63:32];
      2'd3:    bus.word_out = head[31:0];
      default: bus.word_out = head[127:96];
    endcase
  end

  assign xfer = bus.word_valid && bus.word_ready;
  assign pop  = xfer && (widx == 2'd3);
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign push = bus.blk_in_valid && (!full || pop);
  assign drop = bus.blk_in_valid && full && !pop;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      widx     <= 2'd0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
`ifdef AES_OUTBUF_DROP_CNT_EN
      drop_cnt <= 16'd0;
`endif
    end else if (flush) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      widx     <= 2'd0;
      overflow <= 1'b0;
`ifdef AES_OUTBUF_DROP_CNT_EN
      drop_cnt <= 16'd0;
`endif
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.blk_in;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (xfer) begin
        widx <= widx + 2'd1;
      end
      count <= count_nxt;
      state <= (count_nxt != '0) ? SEND : IDLE;
      if (drop) begin
        overflow <= 1'b1;
      end
`ifdef AES_OUTBUF_DROP_CNT_EN
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_aes_out_buffer.sv
// Self-checking bench for aes_out_buffer: directed scenarios plus a randomized run against a queue model.
module tb_aes_out_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [CW-1:0] free_cnt;
  logic          empty;
  logic          full;
  logic          overflow;
`ifdef AES_OUTBUF_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  aes_out_buffer_if bus ();

  aes_out_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flush),
    .free_cnt (free_cnt),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
`ifdef AES_OUTBUF_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: queue of whole blocks, index of the next word of the head block.
  logic [127:0] mq[$];
  int           mw    = 0;
  bit           movf  = 0;
  int           mdrop = 0;

  localparam logic [127:0] KBLK = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic [31:0] kw [4] = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};

  function automatic logic exp_valid();
    return mq.size() != 0;
  endfunction

  function automatic logic exp_last();
    return (mq.size() != 0) && (mw == 3);
  endfunction

  function automatic logic [31:0] exp_word();
    logic [127:0] b;
    b = mq[0];
    return b[(3 - mw) * 32 +: 32];
  endfunction

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model_clear();
    mq.delete();
    mw    = 0;
    movf  = 0;
    mdrop = 0;
  endfunction

  // Drive one cycle of inputs, advance past the edge, then update the model.
  task automatic tick(input logic [127:0] b, input logic bv, input logic rdy, input logic fl);
    bit vld_m, full_m, pop_m;
    bus.blk_in       = b;
    bus.blk_in_valid = bv;
    bus.word_ready   = rdy;
    flush            = fl;
    vld_m  = mq.size() > 0;
    full_m = mq.size() == DEPTH;
    pop_m  = vld_m && rdy && (mw == 3);
    @(posedge clk);
    #1;
    if (fl) begin
      model_clear();
    end else begin
      if (vld_m && rdy) begin
        if (mw == 3) begin
          void'(mq.pop_front());
          mw = 0;
        end else begin
          mw++;
        end
      end
      if (bv && (!full_m || pop_m)) begin
        mq.push_back(b);
      end else if (bv) begin
        movf = 1;
        if (mdrop < 65535) mdrop++;
      end
    end
    bus.blk_in_valid = 1'b0;
    flush            = 1'b0;
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    flush            = 1'b0;
    bus.blk_in       = '0;
    bus.blk_in_valid = 1'b0;
    bus.word_ready   = 1'b0;
    #12;
    n_tot++; if (bus.word_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.word_valid); else n_pass++;
    n_tot++; if (bus.word_last !== 1'b0) $display("FAIL reset_last got=%b exp=0", bus.word_last); else n_pass++;
    n_tot++; if (bus.word_out !== 32'h0) $display("FAIL reset_word got=%h exp=0", bus.word_out); else n_pass++;
    n_tot++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else n_pass++;
    n_tot++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else n_pass++;
    n_tot++; if (free_cnt !== CW'(DEPTH)) $display("FAIL reset_free got=%0d exp=%0d", free_cnt, DEPTH); else n_pass++;
    n_tot++; if (overflow !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", overflow); else n_pass++;
`ifdef AES_OUTBUF_DROP_CNT_EN
    n_tot++; if (drop_cnt !== 16'd0) $display("FAIL reset_dropcnt got=%0d exp=0", drop_cnt); else n_pass++;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_single_block();
    tick(KBLK, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_tot++; if (bus.word_valid !== 1'b1) $display("FAIL single_valid w=%0d got=%b exp=1", i, bus.word_valid); else n_pass++;
      n_tot++; if (bus.word_out !== kw[i]) $display("FAIL single_word w=%0d got=%h exp=%h", i, bus.word_out, kw[i]); else n_pass++;
      n_tot++; if (bus.word_last !== (i == 3)) $display("FAIL single_last w=%0d got=%b exp=%b", i, bus.word_last, (i == 3)); else n_pass++;
      tick('0, 1'b0, 1'b1, 1'b0);
    end
    n_tot++; if (empty !== 1'b1) $display("FAIL single_empty got=%b exp=1", empty); else n_pass++;
    n_tot++; if (free_cnt !== CW'(DEPTH)) $display("FAIL single_free got=%0d exp=%0d", free_cnt, DEPTH); else n_pass++;
    n_tot++; if (bus.word_valid !== 1'b0) $display("FAIL single_done_valid got=%b exp=0", bus.word_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    tick(KBLK, 1'b1, 1'b1, 1'b0);
    tick('0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick('0, 1'b0, 1'b0, 1'b0);
      n_tot++; if (bus.word_valid !== 1'b1) $display("FAIL bp_valid c=%0d got=%b exp=1", i, bus.word_valid); else n_pass++;
      n_tot++; if (bus.word_out !== kw[1]) $display("FAIL bp_hold c=%0d got=%h exp=%h", i, bus.word_out, kw[1]); else n_pass++;
      n_tot++; if (bus.word_last !== 1'b0) $display("FAIL bp_last c=%0d got=%b exp=0", i, bus.word_last); else n_pass++;
    end
    tick('0, 1'b0, 1'b1, 1'b0);
    n_tot++; if (bus.word_out !== kw[2]) $display("FAIL bp_resume got=%h exp=%h", bus.word_out, kw[2]); else n_pass++;
    tick('0, 1'b0, 1'b1, 1'b0);
    tick('0, 1'b0, 1'b1, 1'b0);
    n_tot++; if (empty !== 1'b1) $display("FAIL bp_empty got=%b exp=1", empty); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [127:0] sent [5];
    logic [127:0] t;
    logic [31:0]  ew;
    for (int i = 0; i < 5; i++) begin
      sent[i] = rnd_blk();
      tick(sent[i], 1'b1, 1'b0, 1'b0);
    end
    n_tot++; if (full !== 1'b1) $display("FAIL ovf_full got=%b exp=1", full); else n_pass++;
    n_tot++; if (free_cnt !== CW'(0)) $display("FAIL ovf_free got=%0d exp=0", free_cnt); else n_pass++;
    n_tot++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", overflow); else n_pass++;
`ifdef AES_OUTBUF_DROP_CNT_EN
    n_tot++; if (drop_cnt !== 16'd1) $display("FAIL ovf_dropcnt got=%0d exp=1", drop_cnt); else n_pass++;
`endif
    for (int k = 0; k < 16; k++) begin
      t  = sent[k / 4];
      ew = t[(3 - (k % 4)) * 32 +: 32];
      n_tot++; if (bus.word_valid !== 1'b1) $display("FAIL ovf_rd_valid k=%0d got=%b exp=1", k, bus.word_valid); else n_pass++;
      n_tot++; if (bus.word_out !== ew) $display("FAIL ovf_rd_word k=%0d got=%h exp=%h", k, bus.word_out, ew); else n_pass++;
      n_tot++; if (bus.word_last !== ((k % 4) == 3)) $display("FAIL ovf_rd_last k=%0d got=%b exp=%b", k, bus.word_last, ((k % 4) == 3)); else n_pass++;
      tick('0, 1'b0, 1'b1, 1'b0);
    end
    n_tot++; if (empty !== 1'b1) $display("FAIL ovf_drained got=%b exp=1", empty); else n_pass++;
    n_tot++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow); else n_pass++;
    tick('0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_simul_push_pop();
    bit bv;
    for (int i = 0; i < DEPTH; i++) tick(rnd_blk(), 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 48; c++) begin
      n_tot++; if (full !== 1'b1) $display("FAIL spp_full c=%0d got=%b exp=1", c, full); else n_pass++;
      n_tot++; if (overflow !== 1'b0) $display("FAIL spp_ovf c=%0d got=%b exp=0", c, overflow); else n_pass++;
      n_tot++; if (bus.word_out !== exp_word()) $display("FAIL spp_word c=%0d got=%h exp=%h", c, bus.word_out, exp_word()); else n_pass++;
      n_tot++; if (bus.word_last !== exp_last()) $display("FAIL spp_last c=%0d got=%b exp=%b", c, bus.word_last, exp_last()); else n_pass++;
      bv = (mw == 3);
      tick(rnd_blk(), bv, 1'b1, 1'b0);
    end
    for (int c = 0; c < 16; c++) begin
      n_tot++; if (bus.word_out !== exp_word()) $display("FAIL spp_drain c=%0d got=%h exp=%h", c, bus.word_out, exp_word()); else n_pass++;
      tick('0, 1'b0, 1'b1, 1'b0);
    end
    n_tot++; if (empty !== 1'b1) $display("FAIL spp_empty got=%b exp=1", empty); else n_pass++;
  endtask

  task automatic test_flush();
    logic [127:0] nb;
    for (int i = 0; i < 5; i++) tick(rnd_blk(), 1'b1, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b1, 1'b0);
    n_tot++; if (bus.word_out !== exp_word()) $display("FAIL flush_pre_word got=%h exp=%h", bus.word_out, exp_word()); else n_pass++;
    tick(rnd_blk(), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
    n_tot++; if (empty !== 1'b1) $display("FAIL flush_empty got=%b exp=1", empty); else n_pass++;
    n_tot++; if (bus.word_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", bus.word_valid); else n_pass++;
    n_tot++; if (overflow !== 1'b0) $display("FAIL flush_ovf got=%b exp=0", overflow); else n_pass++;
    n_tot++; if (free_cnt !== CW'(DEPTH)) $display("FAIL flush_free got=%0d exp=%0d", free_cnt, DEPTH); else n_pass++;
`ifdef AES_OUTBUF_DROP_CNT_EN
    n_tot++; if (drop_cnt !== 16'd0) $display("FAIL flush_dropcnt got=%0d exp=0", drop_cnt); else n_pass++;
`endif
    nb = rnd_blk();
    tick(nb, 1'b1, 1'b1, 1'b0);
    n_tot++; if (bus.word_out !== nb[127:96]) $display("FAIL flush_next_word got=%h exp=%h", bus.word_out, nb[127:96]); else n_pass++;
    n_tot++; if (bus.word_last !== 1'b0) $display("FAIL flush_next_last got=%b exp=0", bus.word_last); else n_pass++;
    for (int i = 0; i < 4; i++) tick('0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    logic [127:0] nb;
    logic [31:0]  ew;
    for (int i = 0; i < 5; i++) tick(rnd_blk(), 1'b1, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_tot++; if (bus.word_valid !== 1'b0) $display("FAIL arst_valid got=%b exp=0", bus.word_valid); else n_pass++;
    n_tot++; if (bus.word_last !== 1'b0) $display("FAIL arst_last got=%b exp=0", bus.word_last); else n_pass++;
    n_tot++; if (bus.word_out !== 32'h0) $display("FAIL arst_word got=%h exp=0", bus.word_out); else n_pass++;
    n_tot++; if (empty !== 1'b1) $display("FAIL arst_empty got=%b exp=1", empty); else n_pass++;
    n_tot++; if (full !== 1'b0) $display("FAIL arst_full got=%b exp=0", full); else n_pass++;
    n_tot++; if (free_cnt !== CW'(DEPTH)) $display("FAIL arst_free got=%0d exp=%0d", free_cnt, DEPTH); else n_pass++;
    n_tot++; if (overflow !== 1'b0) $display("FAIL arst_ovf got=%b exp=0", overflow); else n_pass++;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    nb = rnd_blk();
    tick(nb, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ew = nb[(3 - i) * 32 +: 32];
      n_tot++; if (bus.word_out !== ew) $display("FAIL arst_after_word w=%0d got=%h exp=%h", i, bus.word_out, ew); else n_pass++;
      tick('0, 1'b0, 1'b1, 1'b0);
    end
    n_tot++; if (empty !== 1'b1) $display("FAIL arst_after_empty got=%b exp=1", empty); else n_pass++;
  endtask

  task automatic test_random();
    logic [CW-1:0] ef;
    for (int c = 0; c < 400; c++) begin
      ef = CW'(DEPTH - mq.size());
      n_tot++; if (bus.word_valid !== exp_valid()) $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.word_valid, exp_valid()); else n_pass++;
      n_tot++; if (bus.word_last !== exp_last()) $display("FAIL rnd_last c=%0d got=%b exp=%b", c, bus.word_last, exp_last()); else n_pass++;
      if (exp_valid()) begin
        n_tot++; if (bus.word_out !== exp_word()) $display("FAIL rnd_word c=%0d got=%h exp=%h", c, bus.word_out, exp_word()); else n_pass++;
      end
      n_tot++; if (free_cnt !== ef) $display("FAIL rnd_free c=%0d got=%0d exp=%0d", c, free_cnt, ef); else n_pass++;
      n_tot++; if (full !== (mq.size() == DEPTH)) $display("FAIL rnd_full c=%0d got=%b exp=%b", c, full, (mq.size() == DEPTH)); else n_pass++;
      n_tot++; if (empty !== (mq.size() == 0)) $display("FAIL rnd_empty c=%0d got=%b exp=%b", c, empty, (mq.size() == 0)); else n_pass++;
      n_tot++; if (overflow !== movf) $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, overflow, movf); else n_pass++;
`ifdef AES_OUTBUF_DROP_CNT_EN
      n_tot++; if (drop_cnt !== 16'(mdrop)) $display("FAIL rnd_dropcnt c=%0d got=%0d exp=%0d", c, drop_cnt, mdrop); else n_pass++;
`endif
      tick(rnd_blk(), ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 3));
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_backpressure();
    test_overflow();
    test_simul_push_pop();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/aes_out_buffer.md
# aes_out_buffer

Output buffer and word serializer sitting directly downstream of the 10-round encryption pipeline. It captures each 128-bit ciphertext block the pipeline emits (the pipeline has no backpressure), holds blocks in a small FIFO, and streams them out as 32-bit words over a valid/ready handshake. A free-slot count lets the upstream controller throttle `start` so no block is lost.

## Interface
- `DEPTH`, 4: FIFO depth in 128-bit blocks; power of two, ≥ 2.
- `CW`, `$clog2(DEPTH+1)`: width of `free_cnt`; derived, do not override.

- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `blk_in`  in  128  ciphertext from pipeline `out`.
- `blk_in_valid`  in  1  pipeline `out_valid`; one block per asserted cycle.
- `flush`  in  1  synchronous clear of FIFO, serializer and `overflow`.
- `word_out`  out  32  current output word.
- `word_valid`  out  1  `word_out` is valid.
- `word_ready`  in  1  consumer accepts the word this cycle.
- `word_last`  out  1  high with the 4th (final) word of a block.
- `free_cnt`  out  CW  empty FIFO slots (0..DEPTH).
- `empty`  out  1  FIFO holds no block.
- `full`  out  1  FIFO holds DEPTH blocks.
- `overflow`  out  1  sticky: a block was dropped.

## Operation
- FIFO: DEPTH×128 storage, wrapping read/write pointers (log2 DEPTH bits) plus occupancy counter `count` (0..DEPTH). `full` = count==DEPTH, `empty` = count==0, `free_cnt` = DEPTH−count. All registered-state-derived.
- Serializer: 2-bit word index `widx`. States: IDLE (empty) and SEND (not empty). `word_valid` = !empty. `word_out` = head block slice selected by `widx`, MSW first: widx 0 → [127:96], 1 → [95:64], 2 → [63:32], 3 → [31:0]. `word_last` = word_valid && widx==3.
- Word transfer = word_valid && word_ready: widx increments; at widx==3 it wraps to 0 and the head block is popped (read pointer advances).
- Push = blk_in_valid && (!full || pop this cycle). Push and pop in the same cycle leave `count` unchanged; pointers both advance, wrapping mod DEPTH.
- Drop = blk_in_valid && full && no pop: block discarded, storage untouched, `overflow` set (stays high until `flush` or `rst`).
- `word_out`/`word_last` must hold stable while word_valid && !word_ready.
- `flush` has priority over push, pop and drop: next cycle count=0, pointers=0, widx=0, overflow=0. A block presented on the flush cycle is discarded without setting overflow.
- Reset (`rst` asserted, any time, including mid-block): count=0, pointers=0, widx=0, overflow=0; outputs: word_valid=0, word_last=0, word_out=0 (storage reset to zero), empty=1, full=0, free_cnt=DEPTH.

## Timing
- Latency: block pushed at edge N → word_valid=1 with word 0 during cycle N+1 (1 cycle).
- Throughput with word_ready held high: one word per cycle, one block per 4 cycles; back-to-back blocks have no bubble (word 0 of next block follows word 3 of previous).
- `free_cnt` reflects a push/pop in the cycle after the edge that performed it. Upstream must keep blocks in flight (≤ 11 in pipeline) ≤ free_cnt; not enforced here.

## Configuration
- `AES_OUTBUF_DROP_CNT_EN`: when defined, adds output `drop_cnt` (16 bits, reset 0) incrementing on every drop, saturating at 16'hFFFF, cleared by `flush`; `overflow` unchanged. When undefined, the port and counter do not exist; all other behaviour identical.

## Test plan
- Single block: blk_in=69c4e0d86a7b0430d8cdb78070b4c55a, word_ready=1 → words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a on cycles N+1..N+4, word_last only on 4th, then empty=1, free_cnt=4.
- Backpressure: word_ready=0 for 5 cycles after word 1 → word_out holds 6a7b0430 with word_valid=1; resumes with d8cdb780 when ready rises.
- Fill/overflow (DEPTH=4, word_ready=0): 5 consecutive blocks → full=1, free_cnt=0, overflow=1 after 5th, first 4 blocks read back intact in order; with macro, drop_cnt=1.
- Full with simultaneous push and pop (word 3 accepted same cycle as 5th block) → no drop, overflow=0, count stays 4, pointers wrap correctly across ≥ 3 fills.
- Flush mid-block (after word 1) with a block arriving same cycle → next cycle empty=1, word_valid=0, overflow=0, free_cnt=4; next block starts at word 0.
- Async reset asserted mid-block between edges → outputs reach reset values immediately; after release, a new block serializes from word 0.
